// File: rtl/mine_pkg.sv
// ----------------------------------------------------------------------------
// mine_pkg: shared types and constants for the mine placer -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mine_pkg;

  localparam int MAX_DIM_DEF   = 16;
  localparam int MAX_MINES_DEF = 63;
  localparam int SAFE_RADIUS   = 1;
  localparam int SAFE_CELLS    = (2 * SAFE_RADIUS + 1) * (2 * SAFE_RADIUS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Unsigned distance; board edges never wrap.
  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mine_placer.sv
// ----------------------------------------------------------------------------
// mine_placer: fills an N x N board with M mines from an external random
// coordinate stream, keeping the first-click neighbourhood clear -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mine_placer
  import mine_pkg::*;
#(
  parameter int MAX_DIM   = MAX_DIM_DEF,
  parameter int MAX_MINES = MAX_MINES_DEF,
  parameter int CW        = $clog2(MAX_DIM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [4:0]                 dimension_size,
  input  logic [5:0]                 mines,
  input  logic [CW-1:0]              safe_x,
  input  logic [CW-1:0]              safe_y,
  input  logic [CW-1:0]              rand_x,
  input  logic [CW-1:0]              rand_y,
  output logic [MAX_DIM*MAX_DIM-1:0] mine_map,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [5:0]                 mines_placed
);

  localparam int MAP_W = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(MAP_W);

  state_e            state_q, state_d;
  logic [MAP_W-1:0]  map_q, map_d;
  logic [5:0]        placed_q, placed_d;
  logic [4:0]        n_q, n_d;
  logic [5:0]        m_q, m_d;
  logic [CW-1:0]     sx_q, sx_d;
  logic [CW-1:0]     sy_q, sy_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_ok;
  logic [IDX_W-1:0]  cand_idx;
  logic [MAP_W-1:0]  cand_mask;
  logic              cand_in_range;
  logic              cand_in_safe;
  logic              cand_ok;
  logic [5:0]        placed_inc;

  always_comb begin
    cfg_ok = (32'(dimension_size) >= 4)
          && (32'(dimension_size) <= MAX_DIM)
          && (32'(mines) <= MAX_MINES)
          && (32'(mines) + SAFE_CELLS <= 32'(dimension_size) * 32'(dimension_size))
          && (32'(safe_x) < 32'(dimension_size))
          && (32'(safe_y) < 32'(dimension_size));
  end

  // Candidate filter against the configuration latched at start.
  always_comb begin
    cand_idx      = IDX_W'(rand_y) * IDX_W'(MAX_DIM) + IDX_W'(rand_x);
    cand_mask     = MAP_W'(1) << cand_idx;
    cand_in_range = (32'(rand_x) < 32'(n_q)) && (32'(rand_y) < 32'(n_q));
    cand_in_safe  = (abs_diff(32'(rand_x), 32'(sx_q)) <= SAFE_RADIUS)
                 && (abs_diff(32'(rand_y), 32'(sy_q)) <= SAFE_RADIUS);
    cand_ok       = cand_in_range && !(|(map_q & cand_mask)) && !cand_in_safe;
    placed_inc    = placed_q + 6'd1;
  end

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    placed_d  = placed_q;
    n_d       = n_q;
    m_d       = m_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            n_d     = dimension_size;
            m_d     = mines;
            sx_d    = safe_x;
            sy_d    = safe_y;
            state_d = ST_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        map_d    = '0;
        placed_d = '0;
        state_d  = (m_q == 6'd0) ? ST_DONE : ST_PLACE;
      end
      ST_PLACE: begin
        if (cand_ok) begin
          map_d    = map_q | cand_mask;
          placed_d = placed_inc;
          if (placed_inc == m_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      map_q     <= '0;
      placed_q  <= '0;
      n_q       <= '0;
      m_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      placed_q  <= placed_d;
      n_q       <= n_d;
      m_q       <= m_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign mine_map     = map_q;
  assign mines_placed = placed_q;
  assign cfg_err      = cfg_err_q;
  assign busy         = (state_q == ST_CLEAR) || (state_q == ST_PLACE);
  assign done         = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mine_placer.sv
// ----------------------------------------------------------------------------
// tb_mine_placer: scoreboard bench for mine_placer -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mine_placer;

  localparam int DIM = 16;
  localparam int MW  = DIM * DIM;

  typedef struct {
    logic [MW-1:0] map;
    int            cnt;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    dimension_size = '0;
  logic [5:0]    mines = '0;
  logic [3:0]    safe_x = '0, safe_y = '0, rand_x = '0, rand_y = '0;
  logic [MW-1:0] mine_map;
  logic          busy, done, cfg_err;
  logic [5:0]    mines_placed;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_lat = 0;
  int            rand_hi = 15;
  logic [MW-1:0] model_map = '0;
  logic [MW-1:0] last_map = '0;
  int            model_cnt = 0;
  int            rx_q[$];
  int            ry_q[$];
  exp_t          sb[$];

  mine_placer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dimension_size(dimension_size),
    .mines(mines), .safe_x(safe_x), .safe_y(safe_y), .rand_x(rand_x), .rand_y(rand_y),
    .mine_map(mine_map), .busy(busy), .done(done), .cfg_err(cfg_err),
    .mines_placed(mines_placed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit model_accept(input int x, input int y, input int n, input int sx, input int sy);
    if (x >= n || y >= n) return 1'b0;
    if (adiff(x, sx) <= 1 && adiff(y, sy) <= 1) return 1'b0;
    return !model_map[8'(y * DIM + x)];
  endfunction

  function automatic int popc(input logic [MW-1:0] v);
    int c = 0;
    for (int i = 0; i < MW; i++) c += int'(v[i]);
    return c;
  endfunction

  // Drives one board generation, predicting the result as candidates go out.
  task automatic run_board(input string tag, input int n, input int m, input int sx, input int sy,
                           input int abort_at, input int glitch_at, input bit start_on_done);
    int   t0, pcyc, x, y;
    bit   finished, got;
    exp_t e;
    @(negedge clk);
    start = 1'b1; dimension_size = 5'(n); mines = 6'(m); safe_x = 4'(sx); safe_y = 4'(sy);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b, want 1", tag, busy);
    end
    model_map = '0; model_cnt = 0; pcyc = 0; finished = 1'b0;
    if (m == 0) begin
      e.map = '0; e.cnt = 0; e.lat = 2; sb.push_back(e); finished = 1'b1;
    end
    for (int i = 0; i < 4000 && !finished; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || mines_placed !== 6'(model_cnt)) begin
        n_fail++;
        $display("FAIL %s place_status: busy=%b done=%b placed=%0d, want busy=1 done=0 placed=%0d",
                 tag, busy, done, mines_placed, model_cnt);
      end
      if (abort_at >= 0 && model_cnt == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mine_map !== '0 || mines_placed !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s async_reset: placed=%0d busy=%b done=%b cfg_err=%b map_pop=%0d, want all 0",
                   tag, mines_placed, busy, done, cfg_err, popc(mine_map));
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mines_placed !== 6'd0 || mine_map !== '0) begin
          n_fail++;
          $display("FAIL %s idle_after_reset: busy=%b placed=%0d, want 0 0", tag, busy, mines_placed);
        end
        last_map = '0;
        rx_q.delete(); ry_q.delete();
        return;
      end
      if (i == glitch_at) begin
        start = 1'b1; dimension_size = 5'd5; mines = 6'd2; safe_x = 4'd0; safe_y = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (rx_q.size() > 0) begin
        x = rx_q.pop_front(); y = ry_q.pop_front();
      end else begin
        x = int'($urandom_range(0, rand_hi)); y = int'($urandom_range(0, rand_hi));
      end
      rand_x = 4'(x); rand_y = 4'(y);
      pcyc++;
      if (model_accept(x, y, n, sx, sy)) begin
        model_map[8'(y * DIM + x)] = 1'b1;
        model_cnt++;
      end
      if (model_cnt == m) begin
        e.map = model_map; e.cnt = m; e.lat = 2 + pcyc; sb.push_back(e); finished = 1'b1;
      end
    end
    rx_q.delete(); ry_q.delete();
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL %s stimulus_budget: placed %0d, want %0d", tag, model_cnt, m);
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL %s done_timeout: no done seen, want done after %0d cycles", tag, e.lat);
      return;
    end
    last_lat = cyc - t0;
    if (last_lat != e.lat || mine_map !== e.map || mines_placed !== 6'(e.cnt)) begin
      n_fail++;
      $display("FAIL %s result: lat=%0d placed=%0d pop=%0d map_ok=%b, want lat=%0d placed=%0d pop=%0d",
               tag, last_lat, mines_placed, popc(mine_map), mine_map === e.map, e.lat, e.cnt, popc(e.map));
    end
    last_map = e.map;
    if (start_on_done) begin
      start = 1'b1; dimension_size = 5'd8; mines = 6'd3; safe_x = 4'd1; safe_y = 4'd1;
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mine_map !== e.map) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b busy=%b map_hold=%b, want 0 0 1", tag, done, busy, mine_map === e.map);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mine_map !== '0 || mines_placed !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: placed=%0d busy=%b done=%b cfg_err=%b, want all 0", mines_placed, busy, done, cfg_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reject_filter();
    rx_q = '{3, 5, 9, 6};
    ry_q = '{3, 5, 2, 6};
    run_board("reject", 8, 1, 4, 4, -1, -1, 1'b0);
    n_checks++;
    if (last_lat != 6 || mine_map[6 * DIM + 6] !== 1'b1 || popc(mine_map) != 1) begin
      n_fail++;
      $display("FAIL reject_fixed: lat=%0d bit66=%b pop=%0d, want 6 1 1", last_lat, mine_map[6 * DIM + 6], popc(mine_map));
    end
  endtask

  task automatic test_raster();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        rx_q.push_back(x); ry_q.push_back(y);
      end
    run_board("raster", 8, 10, 0, 0, -1, -1, 1'b0);
    n_checks++;
    if (popc(mine_map) != 10 || mine_map[0] !== 1'b0 || mine_map[1] !== 1'b0 ||
        mine_map[DIM] !== 1'b0 || mine_map[DIM + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL raster_fixed: pop=%0d corner=%b%b%b%b, want 10 0000", popc(mine_map),
               mine_map[0], mine_map[1], mine_map[DIM], mine_map[DIM + 1]);
    end
  endtask

  task automatic test_cfg_err();
    int cfg [5][4] = '{'{4, 8, 0, 0}, '{3, 0, 0, 0}, '{17, 1, 0, 0}, '{8, 1, 8, 0}, '{8, 1, 0, 8}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b1; dimension_size = 5'(cfg[k][0]); mines = 6'(cfg[k][1]);
      safe_x = 4'(cfg[k][2]); safe_y = 4'(cfg[k][3]);
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL cfg_err_pulse[%0d]: cfg_err=%b busy=%b, want 1 0", k, cfg_err, busy);
      end
      @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || mine_map !== last_map) begin
        n_fail++;
        $display("FAIL cfg_err_after[%0d]: cfg_err=%b busy=%b map_hold=%b, want 0 0 1", k, cfg_err, busy, mine_map === last_map);
      end
    end
  endtask

  task automatic test_zero_mines();
    run_board("zero", 10, 0, 5, 5, -1, -1, 1'b1);
    n_checks++;
    if (last_lat != 2 || mine_map !== '0) begin
      n_fail++; $display("FAIL zero_fixed: lat=%0d pop=%0d, want 2 0", last_lat, popc(mine_map));
    end
  endtask

  task automatic test_start_during_place();
    rand_hi = 15;
    run_board("glitch", 16, 40, 7, 7, -1, 5, 1'b0);
    n_checks++;
    if (popc(mine_map) != 40 || mines_placed !== 6'd40) begin
      n_fail++; $display("FAIL glitch_fixed: pop=%0d placed=%0d, want 40 40", popc(mine_map), mines_placed);
    end
  endtask

  task automatic test_full_boundary();
    rand_hi = 3;
    run_board("full4", 4, 7, 1, 1, -1, -1, 1'b0);
    rand_hi = 15;
    run_board("corner", 10, 10, 9, 9, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_place();
    rand_hi = 15;
    run_board("abort", 10, 10, 0, 0, 5, -1, 1'b0);
    run_board("recover", 10, 10, 3, 3, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reject_filter();
    test_raster();
    test_cfg_err();
    test_zero_mines();
    test_start_during_place();
    test_full_boundary();
    test_reset_mid_place();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
